// File: rtl/alu_exec_ctrl.sv
// Single-issue ALU sequencer for the Jac1-8 core: IDLE -> READ -> EXEC -> WB, four cycles per instruction.
// Build option ALU_ILLEGAL_TRAP_EN: illegal opcodes lock the controller in TRAP until reset.
module alu_exec_ctrl #(
    parameter int DataWidth     = 8,
    parameter int NumOpCodeBits = 5,
    parameter int ParamBits     = 8,
    parameter int NumStatusBits = 6,
    parameter int RegAddrBits   = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [NumOpCodeBits-1:0] req_opcode,
    input  logic [RegAddrBits-1:0]   req_dst,
    input  logic [RegAddrBits-1:0]   req_src1,
    input  logic [RegAddrBits-1:0]   req_src2,
    input  logic [ParamBits-1:0]     req_param,
    output logic [RegAddrBits-1:0]   rf_raddr1,
    output logic [RegAddrBits-1:0]   rf_raddr2,
    input  logic [DataWidth-1:0]     rf_rdata1,
    input  logic [DataWidth-1:0]     rf_rdata2,
    output logic [NumOpCodeBits-1:0] alu_opcode,
    output logic [DataWidth-1:0]     alu_operand1,
    output logic [DataWidth-1:0]     alu_operand2,
    output logic [ParamBits-1:0]     alu_param,
    input  logic [DataWidth-1:0]     alu_result,
    input  logic [NumStatusBits-1:0] alu_status,
    output logic                     rf_we,
    output logic [RegAddrBits-1:0]   rf_waddr,
    output logic [DataWidth-1:0]     rf_wdata,
    output logic [NumStatusBits-1:0] status_q,
    output logic                     done,
    output logic                     illegal
);

    localparam logic [NumOpCodeBits-1:0] OP_NOP = NumOpCodeBits'(0);
    localparam logic [NumOpCodeBits-1:0] OP_VAL = NumOpCodeBits'(9);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        EXEC = 3'd2,
        WB   = 3'd3,
        TRAP = 3'd4
    } state_t;

    state_t                   state_reg, state_next;
    logic                     accept;

    logic [NumOpCodeBits-1:0] opcode_reg;
    logic [RegAddrBits-1:0]   dst_reg;
    logic [RegAddrBits-1:0]   src1_reg;
    logic [RegAddrBits-1:0]   src2_reg;
    logic [ParamBits-1:0]     param_reg;

    logic [NumOpCodeBits-1:0] alu_opcode_reg;
    logic [DataWidth-1:0]     alu_operand1_reg;
    logic [DataWidth-1:0]     alu_operand2_reg;
    logic [ParamBits-1:0]     alu_param_reg;

    logic [DataWidth-1:0]     result_reg;
    logic [NumStatusBits-1:0] status_cap_reg;
    logic [NumStatusBits-1:0] status_reg;
`ifdef ALU_ILLEGAL_TRAP_EN
    logic                     illegal_reg;
`endif

    logic                     is_nop;
    logic                     is_val;
    logic                     is_illegal;
    logic                     is_write;
    logic [DataWidth-1:0]     param_ext;
    logic [NumStatusBits-1:0] val_status;

    assign is_nop     = (opcode_reg == OP_NOP);
    assign is_val     = (opcode_reg == OP_VAL);
    assign is_illegal = (opcode_reg > OP_VAL);
    assign is_write   = !is_nop && !is_illegal;

    // VAL writes the immediate, truncated or zero-extended to the data width
    genvar gi;
    generate
        for (gi = 0; gi < DataWidth; gi++) begin : g_param_ext
            if (gi < ParamBits) begin : g_bit
                assign param_ext[gi] = param_reg[gi];
            end else begin : g_zero
                assign param_ext[gi] = 1'b0;
            end
        end
        for (gi = 0; gi < NumStatusBits; gi++) begin : g_val_status
            if (gi == 2) begin : g_zero_flag
                assign val_status[gi] = (param_reg == '0);
            end else begin : g_clear
                assign val_status[gi] = 1'b0;
            end
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        req_ready  = 1'b0;
        rf_we      = 1'b0;
        done       = 1'b0;
        illegal    = 1'b0;
        // Address goes out combinationally in IDLE so the synchronous RF returns data during READ
        rf_raddr1  = src1_reg;
        rf_raddr2  = src2_reg;
        case (state_reg)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept     = 1'b1;
                    rf_raddr1  = req_src1;
                    rf_raddr2  = req_src2;
                    state_next = READ;
                end
            end
            READ: state_next = EXEC;
            EXEC: state_next = WB;
            WB: begin
                rf_we = is_write;
`ifdef ALU_ILLEGAL_TRAP_EN
                if (is_illegal) begin
                    state_next = TRAP;
                end else begin
                    done       = 1'b1;
                    state_next = IDLE;
                end
`else
                done       = 1'b1;
                illegal    = is_illegal;
                state_next = IDLE;
`endif
            end
            TRAP: state_next = TRAP;
            default: state_next = IDLE;
        endcase
`ifdef ALU_ILLEGAL_TRAP_EN
        illegal = illegal_reg;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= IDLE;
            opcode_reg       <= '0;
            dst_reg          <= '0;
            src1_reg         <= '0;
            src2_reg         <= '0;
            param_reg        <= '0;
            alu_opcode_reg   <= '0;
            alu_operand1_reg <= '0;
            alu_operand2_reg <= '0;
            alu_param_reg    <= '0;
            result_reg       <= '0;
            status_cap_reg   <= '0;
            status_reg       <= '0;
`ifdef ALU_ILLEGAL_TRAP_EN
            illegal_reg      <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            if (accept) begin
                opcode_reg <= req_opcode;
                dst_reg    <= req_dst;
                src1_reg   <= req_src1;
                src2_reg   <= req_src2;
                param_reg  <= req_param;
            end
            if (state_reg == READ) begin
                alu_opcode_reg   <= opcode_reg;
                alu_operand1_reg <= rf_rdata1;
                alu_operand2_reg <= rf_rdata2;
                alu_param_reg    <= param_reg;
            end
            if (state_reg == EXEC) begin
                result_reg     <= is_val ? param_ext : alu_result;
                status_cap_reg <= is_val ? val_status : alu_status;
            end
            if (state_reg == WB && is_write) begin
                status_reg <= status_cap_reg;
            end
`ifdef ALU_ILLEGAL_TRAP_EN
            if (state_reg == WB && is_illegal) begin
                illegal_reg <= 1'b1;
            end
`endif
        end
    end

    assign alu_opcode   = alu_opcode_reg;
    assign alu_operand1 = alu_operand1_reg;
    assign alu_operand2 = alu_operand2_reg;
    assign alu_param    = alu_param_reg;
    assign rf_waddr     = dst_reg;
    assign rf_wdata     = result_reg;
    assign status_q     = status_reg;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Scoreboard bench for alu_exec_ctrl with a behavioural register file and ALU_J model around it.
module tb_alu_exec_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [4:0] req_opcode;
    logic [2:0] req_dst, req_src1, req_src2;
    logic [7:0] req_param;
    logic [2:0] rf_raddr1, rf_raddr2;
    logic [7:0] rf_rdata1, rf_rdata2;
    logic [4:0] alu_opcode;
    logic [7:0] alu_operand1, alu_operand2, alu_param, alu_result;
    logic [5:0] alu_status;
    logic       rf_we;
    logic [2:0] rf_waddr;
    logic [7:0] rf_wdata;
    logic [5:0] status_q;
    logic       done, illegal;

    int n_vec  = 0;
    int n_fail = 0;
    int cyc    = 0;

    typedef struct {
        int         cyc;
        logic [4:0] op;
        logic [2:0] dst;
        logic       we;
        logic [7:0] wd;
        logic [5:0] st;
        logic       ill;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_exec_ctrl dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
        .req_dst(req_dst), .req_src1(req_src1), .req_src2(req_src2), .req_param(req_param),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .alu_opcode(alu_opcode), .alu_operand1(alu_operand1), .alu_operand2(alu_operand2),
        .alu_param(alu_param), .alu_result(alu_result), .alu_status(alu_status),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .status_q(status_q), .done(done), .illegal(illegal)
    );

    // Register file: synchronous read, no write-through
    logic [7:0] rf_mem [8];
    always @(posedge clk) begin
        if (rf_we) rf_mem[rf_waddr] <= rf_wdata;
        rf_rdata1 <= rf_mem[rf_raddr1];
        rf_rdata2 <= rf_mem[rf_raddr2];
    end

    // ALU_J: status = {smaller, greater, equal, zero, underflow, overflow}
    logic [8:0] alu_wide;
    logic       alu_ovf, alu_und;
    always_comb begin
        alu_wide   = '0;
        alu_result = '0;
        alu_ovf    = 1'b0;
        alu_und    = 1'b0;
        case (alu_opcode)
            5'd1: begin
                alu_wide   = {1'b0, alu_operand1} + {1'b0, alu_operand2};
                alu_result = alu_wide[7:0];
                alu_ovf    = alu_wide[8];
            end
            5'd2: begin
                alu_result = alu_operand1 - alu_operand2;
                alu_und    = alu_operand1 < alu_operand2;
            end
            5'd3: alu_result = alu_operand1 & alu_operand2;
            5'd4: alu_result = alu_operand1 | alu_operand2;
            5'd5: alu_result = ~alu_operand1;
            5'd6: alu_result = alu_operand1 ^ alu_operand2;
            5'd7: alu_result = alu_operand1 << alu_param;
            5'd8: alu_result = alu_operand1 >> alu_param;
            default: alu_result = '0;
        endcase
        alu_status = {alu_operand1 < alu_operand2, alu_operand1 > alu_operand2,
                      alu_operand1 == alu_operand2, alu_result == 8'd0, alu_und, alu_ovf};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [4:0] op, input logic [2:0] dst, input logic [2:0] s1,
                         input logic [2:0] s2, input logic [7:0] prm, input bit hold, input bit push,
                         input bit we, input logic [7:0] wd, input logic [5:0] st, input bit ill);
        int   guard = 0;
        exp_t e;
        @(negedge clk);
        while (!req_ready && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            check("ready_timeout", 32'(req_ready), 32'd1);
            return;
        end
        req_valid  = 1'b1;
        req_opcode = op;
        req_dst    = dst;
        req_src1   = s1;
        req_src2   = s2;
        req_param  = prm;
        e.cyc = cyc + 3; e.op = op; e.dst = dst; e.we = we; e.wd = wd; e.st = st; e.ill = ill;
        if (push) q.push_back(e);
        @(posedge clk);
        #1;
        if (!hold) req_valid = 1'b0;
    endtask

    // Monitor: pops one expectation per done pulse, checks status_q on the following cycle
    initial begin
        bit         pend_status = 1'b0;
        logic [5:0] pend_val    = '0;
        exp_t       e;
        forever begin
            @(negedge clk);
            if (pend_status) begin
                check("status_q", 32'(status_q), 32'(pend_val));
                pend_status = 1'b0;
            end
            if (done) begin
                if (q.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'd0);
                end else begin
                    e = q.pop_front();
                    $display("txn op=%0d dst=%0d we=%0b wdata=%0h cyc=%0d", e.op, e.dst, rf_we, rf_wdata, cyc);
                    check("done_cycle", 32'(cyc), 32'(e.cyc));
                    check("rf_we", 32'(rf_we), 32'(e.we));
                    check("illegal", 32'(illegal), 32'(e.ill));
                    if (e.we) begin
                        check("rf_waddr", 32'(rf_waddr), 32'(e.dst));
                        check("rf_wdata", 32'(rf_wdata), 32'(e.wd));
                    end
                    pend_status = 1'b1;
                    pend_val    = e.st;
                end
            end else if (rf_we) begin
                check("stray_rf_we", 32'(rf_we), 32'd0);
`ifndef ALU_ILLEGAL_TRAP_EN
            end else if (illegal) begin
                check("stray_illegal", 32'(illegal), 32'd0);
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_opcode = '0;
        req_dst = '0; req_src1 = '0; req_src2 = '0; req_param = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rf_we", 32'(rf_we), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);
        check("rst_status_q", 32'(status_q), 32'd0);
        check("rst_alu_opcode", 32'(alu_opcode), 32'd0);
        check("rst_alu_operand1", 32'(alu_operand1), 32'd0);
        check("rst_rf_raddr1", 32'(rf_raddr1), 32'd0);
        check("rst_rf_wdata", 32'(rf_wdata), 32'd0);

        //     op     dst   s1    s2    param  hold push we  wdata  status     ill
        issue(5'd9, 3'd0, 3'd0, 3'd0, 8'd1,   0,   1,   1, 8'd1,   6'b000000, 0);
        issue(5'd9, 3'd1, 3'd0, 3'd0, 8'd3,   0,   1,   1, 8'd3,   6'b000000, 0);
        issue(5'd1, 3'd2, 3'd0, 3'd1, 8'd0,   0,   1,   1, 8'd4,   6'b100000, 0);
        issue(5'd9, 3'd0, 3'd0, 3'd0, 8'd14,  0,   1,   1, 8'd14,  6'b000000, 0);
        issue(5'd9, 3'd1, 3'd0, 3'd0, 8'd15,  0,   1,   1, 8'd15,  6'b000000, 0);
        issue(5'd2, 3'd3, 3'd0, 3'd1, 8'd0,   0,   1,   1, 8'd255, 6'b100010, 0);
        issue(5'd0, 3'd6, 3'd0, 3'd1, 8'd0,   0,   1,   0, 8'd0,   6'b100010, 0);
        issue(5'd9, 3'd0, 3'd0, 3'd0, 8'd6,   0,   1,   1, 8'd6,   6'b000000, 0);
        issue(5'd7, 3'd4, 3'd0, 3'd0, 8'd3,   0,   1,   1, 8'h30,  6'b001000, 0);
        issue(5'd9, 3'd5, 3'd0, 3'd0, 8'd0,   0,   1,   1, 8'd0,   6'b000100, 0);
        // req_valid held high across three instructions; the second reads r6 just written
        issue(5'd3, 3'd6, 3'd1, 3'd2, 8'd0,   1,   1,   1, 8'd4,   6'b010000, 0);
        issue(5'd4, 3'd7, 3'd6, 3'd0, 8'd0,   1,   1,   1, 8'd6,   6'b100000, 0);
        issue(5'd6, 3'd0, 3'd7, 3'd3, 8'd0,   0,   1,   1, 8'hF9,  6'b100000, 0);
        issue(5'd5, 3'd1, 3'd0, 3'd0, 8'd0,   0,   1,   1, 8'd6,   6'b001000, 0);
        issue(5'd8, 3'd2, 3'd3, 3'd3, 8'd4,   0,   1,   1, 8'd15,  6'b001000, 0);
        issue(5'd1, 3'd3, 3'd3, 3'd3, 8'd0,   0,   1,   1, 8'd254, 6'b001001, 0);

        // Reset during EXEC of an ADD: the instruction must vanish
        repeat (6) @(negedge clk);
        req_valid = 1'b1; req_opcode = 5'd1; req_dst = 3'd7; req_src1 = 3'd3; req_src2 = 3'd3;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_req_ready", 32'(req_ready), 32'd1);
        check("midrst_status_q", 32'(status_q), 32'd0);
        check("midrst_rf_we", 32'(rf_we), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        repeat (5) @(negedge clk);

        issue(5'd9, 3'd0, 3'd0, 3'd0, 8'd0,   0,   1,   1, 8'd0,   6'b000100, 0);
`ifdef ALU_ILLEGAL_TRAP_EN
        issue(5'd16, 3'd1, 3'd0, 3'd0, 8'd0,  1,   0,   0, 8'd0,   6'b000100, 1);
        repeat (4) @(negedge clk);
        check("trap_illegal", 32'(illegal), 32'd1);
        check("trap_req_ready", 32'(req_ready), 32'd0);
        repeat (6) @(negedge clk);
        check("trap_illegal_sticky", 32'(illegal), 32'd1);
        check("trap_req_ready_held", 32'(req_ready), 32'd0);
        check("trap_status_q", 32'(status_q), 32'b000100);
        req_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("trap_rst_illegal", 32'(illegal), 32'd0);
        check("trap_rst_req_ready", 32'(req_ready), 32'd1);
`else
        issue(5'd16, 3'd1, 3'd0, 3'd0, 8'd0,  0,   1,   0, 8'd0,   6'b000100, 1);
`endif
        issue(5'd9, 3'd4, 3'd0, 3'd0, 8'h5A,  0,   1,   1, 8'h5A,  6'b000000, 0);

        repeat (8) @(negedge clk);
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
